// File: rtl/board_mem_pkg.sv
// Shared types and constants for the board memory client.
package board_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN
  } sweep_state_e;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/board_mem_client_if.sv
// Single-port block-memory bus: initiator drives wen/ren/addr/din, memory returns dout one cycle after ren.
interface board_mem_client_if #(
    parameter int unsigned BITS  = 16,
    parameter int unsigned ABITS = 6
);
    logic             wen;
    logic             ren;
    logic [ABITS-1:0] addr;
    logic [BITS-1:0]  din;
    logic [BITS-1:0]  dout;

    modport master (output wen, output ren, output addr, output din, input dout);
    modport slave  (input wen, input ren, input addr, input din, output dout);
endinterface

// File: rtl/board_mem_skid_fifo.sv
// Two-entry output FIFO holding {last, addr, data} for the sweep stream; push and pop may coincide when full.
module board_mem_skid_fifo
    import board_mem_pkg::*;
#(
    parameter int unsigned W = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [W-1:0]          i_data,
    input  logic                  i_pop,
    output logic                  o_valid,
    output logic [W-1:0]          o_data,
    output logic [FIFO_CNT_W-1:0] o_count
);

    logic [W-1:0]          r_mem [FIFO_DEPTH];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [FIFO_CNT_W-1:0] r_count;
    logic                  w_pop;

    assign o_valid = (r_count != '0);
    assign w_pop   = o_valid && i_pop;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // One-bit pointers toggle because the depth is exactly two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + FIFO_CNT_W'(i_push) - FIFO_CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/board_mem_client.sv
// Merges game-logic cell writes and full-frame read sweeps onto one block-memory port.
// Optional write-starvation guard: define BOARD_MEM_STARVE_GUARD_EN.
module board_mem_client
    import board_mem_pkg::*;
#(
    parameter  int unsigned BITS  = 16,
    parameter  int unsigned WORDS = 64,
    localparam int unsigned ABITS = $clog2(WORDS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    output logic                      o_busy,
    output logic                      o_done,
    input  logic                      i_wr_valid,
    output logic                      o_wr_ready,
    input  logic [ABITS-1:0]          i_wr_addr,
    input  logic [BITS-1:0]           i_wr_data,
    output logic                      o_rd_valid,
    input  logic                      i_rd_ready,
    output logic [BITS-1:0]           o_rd_data,
    output logic [ABITS-1:0]          o_rd_addr,
    output logic                      o_rd_last,
    board_mem_client_if.master        mem
);

    localparam logic [ABITS:0]   LP_WORDS = (ABITS + 1)'(WORDS);
    localparam logic [ABITS-1:0] LP_LAST  = ABITS'(WORDS - 1);
    localparam int unsigned      FW       = BITS + ABITS + 1;

    sweep_state_e          r_state;
    logic [ABITS:0]        r_cnt;
    logic                  r_inflight;
    logic [ABITS-1:0]      r_iss_addr;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_wr;
    logic                  w_pop;
    logic                  w_can_read;
    logic                  w_issue;
    logic                  w_drained;
    logic [FIFO_CNT_W-1:0] w_fifo_cnt;
    logic [FIFO_CNT_W:0]   w_occ;
    logic [FW-1:0]         w_push_data;
    logic [FW-1:0]         w_head;

    assign w_wr  = i_wr_valid && o_wr_ready;
    assign w_pop = o_rd_valid && i_rd_ready;

    // Occupancy counts the slot freed by this cycle's pop so the stream can run at one word per cycle.
    assign w_occ      = {1'b0, w_fifo_cnt} + (FIFO_CNT_W + 1)'(r_inflight) - (FIFO_CNT_W + 1)'(w_pop);
    assign w_can_read = (r_state == SWEEP) && (r_cnt < LP_WORDS) &&
                        (w_occ < (FIFO_CNT_W + 1)'(FIFO_DEPTH));
    assign w_issue    = w_can_read && !w_wr;
    assign w_drained  = !r_inflight && (w_occ == '0);

    always_comb begin
        mem.wen  = 1'b0;
        mem.ren  = 1'b0;
        mem.addr = '0;
        mem.din  = '0;
        if (w_wr) begin
            mem.wen  = 1'b1;
            mem.addr = i_wr_addr;
            mem.din  = i_wr_data;
        end else if (w_issue) begin
            mem.ren  = 1'b1;
            mem.addr = r_cnt[ABITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_inflight <= 1'b0;
            r_iss_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_iss_addr <= r_cnt[ABITS-1:0];
                r_cnt      <= r_cnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= SWEEP;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (r_cnt == LP_WORDS) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_drained) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef BOARD_MEM_STARVE_GUARD_EN
    logic [1:0] r_starve;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if ((r_state != SWEEP) || w_issue) begin
            r_starve <= '0;
        end else if (w_can_read && i_wr_valid) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    assign o_wr_ready = (r_starve != 2'd3);
`else
    assign o_wr_ready = 1'b1;
`endif

    assign w_push_data = {(r_iss_addr == LP_LAST), r_iss_addr, mem.dout};

    board_mem_skid_fifo #(
        .W (FW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_data  (w_push_data),
        .i_pop   (i_rd_ready),
        .o_valid (o_rd_valid),
        .o_data  (w_head),
        .o_count (w_fifo_cnt)
    );

    assign {o_rd_last, o_rd_addr, o_rd_data} = w_head;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule
